// File: rtl/bin_to_seg_feeder.sv
// Binary-to-7-segment feeder: sequential double-dabble, segment encode, strobe/busy handshake.
// Optional leading-zero blanking of digits [0]..[2] is enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_seg_feeder #(
    parameter int unsigned VALUE_W   = 14,
    parameter logic [7:0]  DASH_CODE = 8'h40
) (
    input  logic                clk_i,
    input  logic                porb_i,
    input  logic                sync_reset_i,
    input  logic [VALUE_W-1:0]  value_i,
    input  logic                value_valid_i,
    output logic                value_ready_o,
    output logic [3:0][7:0]     digits_o,
    output logic                disp_strobe_o,
    input  logic                busy_i,
    output logic                overflow_o
);

    localparam int unsigned        CNT_W   = $clog2(VALUE_W);
    localparam logic [VALUE_W-1:0] MAX_DEC = VALUE_W'(9999);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        ARM,
        ACK,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [3:0][7:0]    digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic [3:0][7:0]    enc_digits;
    logic               strobe;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // Double-dabble correction step applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Digit [0] is the thousands nibble bcd_q[15:12]; [3] is the units nibble.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        enc_digits = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            enc_digits[k[1:0]] = seg7(bcd_q[(3-k)*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (k < 3 && lead && bcd_q[(3-k)*4 +: 4] == 4'd0) begin
                enc_digits[k[1:0]] = 8'h00;
            end else begin
                lead = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        strobe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (value_valid_i) begin
                    bin_d      = value_i;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(VALUE_W - 1);
                    ovf_pend_d = (value_i > MAX_DEC);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = 16'({bcd_adj, bin_q[VALUE_W-1]});
                bin_d = {bin_q[VALUE_W-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD: begin
                if (ovf_pend_q) begin
                    digits_d   = {4{DASH_CODE}};
                    overflow_d = 1'b1;
                end else begin
                    digits_d   = enc_digits;
                    overflow_d = 1'b0;
                end
                state_d = ARM;
            end
            ARM: begin
                if (!busy_i) begin
                    strobe  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (busy_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge porb_i) begin
        if (!porb_i) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else if (sync_reset_i) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    assign value_ready_o = (state_q == IDLE);
    assign disp_strobe_o = strobe;
    assign digits_o      = digits_q;
    assign overflow_o    = overflow_q;

endmodule
